// File: rtl/exc_mem_addr_unit.sv
// exc_mem_addr_unit: IorD memory-address mux with an exception vector-fetch sequencer
module exc_mem_addr_unit #(
    parameter int WIDTH    = 32,
    parameter int NUM_EXC  = 3,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic [1:0]                                    i_src_sel,
    input  logic [WIDTH-1:0]                              i_pc,
    input  logic [WIDTH-1:0]                              i_alu_out,
    input  logic [WIDTH-1:0]                              i_result,
    input  logic [NUM_EXC-1:0]                            i_exc_req,
    input  logic [7:0]                                    i_mem_rdata,
    output logic [WIDTH-1:0]                              o_mem_addr,
    output logic                                          o_busy,
    output logic [WIDTH-1:0]                              o_epc,
    output logic                                          o_epc_we,
    output logic [WIDTH-1:0]                              o_handler_pc,
    output logic                                          o_handler_valid,
    output logic [((NUM_EXC > 1) ? $clog2(NUM_EXC) : 1)-1:0] o_exc_cause
);
    localparam int CW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
    localparam int NW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, VEC, DONE} state_t;

    state_t             r_state, w_next;
    logic [NUM_EXC-1:0] r_pending, w_req;
    logic [WIDTH-1:0]   r_last_addr, r_epc, r_handler_pc;
    logic [CW-1:0]      r_cause, w_k;
    logic [NW-1:0]      r_cnt;
    logic               w_found;

    if (MEM_LAT < 1 || VEC_BASE < 0 || (WIDTH < 31 && VEC_BASE + NUM_EXC - 1 >= (1 << WIDTH))) begin : g_bad_params
        $error("exc_mem_addr_unit: illegal MEM_LAT or vector range");
    end

    // Lowest-index request wins; requests not yet serviced stay in r_pending.
    always_comb begin
        w_req   = r_pending | i_exc_req;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_EXC; i++) begin
            if (w_req[i] && !w_found) begin
                w_found = 1'b1;
                w_k     = CW'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state == IDLE ? (w_found ? VEC : IDLE) :
                          r_state == VEC  ? (r_cnt == '0 ? DONE : VEC) : IDLE;
        o_busy          = r_state != IDLE;
        o_epc_we        = r_state == VEC && r_cnt == NW'(MEM_LAT - 1);
        o_handler_valid = r_state == DONE;
        o_mem_addr      = r_state == VEC  ? WIDTH'(VEC_BASE) + WIDTH'(r_cause) :
                          r_state == DONE ? r_last_addr :
                          i_src_sel == 2'd0 ? i_pc :
                          i_src_sel == 2'd1 ? i_alu_out :
                          i_src_sel == 2'd2 ? i_result : r_last_addr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pending    <= '0;
            r_last_addr  <= '0;
            r_epc        <= '0;
            r_handler_pc <= '0;
            r_cause      <= '0;
            r_cnt        <= '0;
        end else begin
            r_pending <= w_req;
            if (r_state == IDLE) begin
                r_last_addr <= o_mem_addr;
                if (w_found) begin
                    r_pending[w_k] <= 1'b0;
                    r_cause        <= w_k;
                    r_epc          <= i_pc - WIDTH'(4);
                    r_cnt          <= NW'(MEM_LAT - 1);
                end
            end else if (r_state == VEC) begin
                if (r_cnt == '0)
                    r_handler_pc <= WIDTH'(i_mem_rdata);
                else
                    r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_epc        = r_epc;
    assign o_handler_pc = r_handler_pc;
    assign o_exc_cause  = r_cause;
endmodule

// File: tb/tb_exc_mem_addr_unit.sv
// tb_exc_mem_addr_unit: two instances (MEM_LAT 1 and 3) against a cycle-phase reference model
module tb_exc_mem_addr_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_sel = '0;
    logic [31:0] pc = '0, alu = '0, res = '0;
    logic [2:0]  req = '0;
    logic [7:0]  rdata [2];
    logic [31:0] addr [2], epc [2], hpc [2];
    logic        busy [2], epc_we [2], hv [2];
    logic [1:0]  cause [2];

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int          lat [2] = '{1, 3};
    bit   [2:0]  m_pend [2];
    int          m_phase [2];
    int          m_cause [2];
    logic [31:0] m_last [2], m_epc [2], m_hpc [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(logic [31:0] a);
        if (a == 32'd253) return 8'h31;
        if (a == 32'd254) return 8'h7C;
        if (a == 32'd255) return 8'hE6;
        return a[7:0] ^ 8'h5A;
    endfunction

    assign rdata[0] = mem_byte(addr[0]);
    assign rdata[1] = mem_byte(addr[1]);

    exc_mem_addr_unit #(.WIDTH(32), .NUM_EXC(3), .VEC_BASE(253), .MEM_LAT(1)) u1 (
        .i_clk(clk), .i_reset(rst_n), .i_src_sel(src_sel), .i_pc(pc), .i_alu_out(alu),
        .i_result(res), .i_exc_req(req), .i_mem_rdata(rdata[0]), .o_mem_addr(addr[0]),
        .o_busy(busy[0]), .o_epc(epc[0]), .o_epc_we(epc_we[0]), .o_handler_pc(hpc[0]),
        .o_handler_valid(hv[0]), .o_exc_cause(cause[0]));

    exc_mem_addr_unit #(.WIDTH(32), .NUM_EXC(3), .VEC_BASE(253), .MEM_LAT(3)) u3 (
        .i_clk(clk), .i_reset(rst_n), .i_src_sel(src_sel), .i_pc(pc), .i_alu_out(alu),
        .i_result(res), .i_exc_req(req), .i_mem_rdata(rdata[1]), .o_mem_addr(addr[1]),
        .o_busy(busy[1]), .o_epc(epc[1]), .o_epc_we(epc_we[1]), .o_handler_pc(hpc[1]),
        .o_handler_valid(hv[1]), .o_exc_cause(cause[1]));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Phase 0 is idle, 1..lat are the vector-fetch cycles, lat+1 is the handoff cycle.
    function automatic logic [31:0] exp_addr(int d);
        if (m_phase[d] == 0)
            return src_sel == 2'd0 ? pc : src_sel == 2'd1 ? alu : src_sel == 2'd2 ? res : m_last[d];
        if (m_phase[d] <= lat[d])
            return 32'(253 + m_cause[d]);
        return m_last[d];
    endfunction

    task automatic sample();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d addr", d), addr[d], exp_addr(d));
            chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_phase[d] != 0));
            chk($sformatf("d%0d epc_we", d), 32'(epc_we[d]), 32'(m_phase[d] == 1));
            chk($sformatf("d%0d hvalid", d), 32'(hv[d]), 32'(m_phase[d] == lat[d] + 1));
            chk($sformatf("d%0d epc", d), epc[d], m_epc[d]);
            chk($sformatf("d%0d hpc", d), hpc[d], m_hpc[d]);
            chk($sformatf("d%0d cause", d), 32'(cause[d]), 32'(m_cause[d]));
        end
    endtask

    task automatic adv();
        logic [31:0] a [2];
        bit   [2:0]  r;
        int          k;
        for (int d = 0; d < 2; d++) a[d] = exp_addr(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_pend[d] = '0; m_phase[d] = 0; m_cause[d] = 0;
                m_last[d] = '0; m_epc[d] = '0; m_hpc[d] = '0;
            end else begin
                r = m_pend[d] | req;
                if (m_phase[d] == 0) begin
                    m_last[d] = a[d];
                    if (r != 0) begin
                        k = 0;
                        while (!r[k]) k++;
                        m_cause[d] = k;
                        m_epc[d]   = pc - 32'd4;
                        r[k]       = 1'b0;
                        m_phase[d] = 1;
                    end
                end else if (m_phase[d] == lat[d] + 1) begin
                    m_phase[d] = 0;
                end else begin
                    if (m_phase[d] == lat[d]) m_hpc[d] = 32'(mem_byte(32'(253 + m_cause[d])));
                    m_phase[d]++;
                end
                m_pend[d] = r;
            end
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    initial begin
        adv(); adv();
        rst_n = 1'b1; pc = 32'h40; alu = 32'h1234; res = 32'hFF00; src_sel = 2'd0;
        sample(); chk("reset busy", 32'(busy[0] | busy[1]), 32'd0);
        chk("sel pc", addr[0], 32'h40); adv();
        src_sel = 2'd1; sample(); chk("sel alu", addr[0], 32'h1234); adv();
        src_sel = 2'd2; sample(); chk("sel result", addr[0], 32'hFF00); adv();
        src_sel = 2'd3; pc = 32'h99; res = 32'h5; sample(); chk("hold", addr[0], 32'hFF00); adv();
        sample(); chk("hold2", addr[1], 32'hFF00); adv();

        src_sel = 2'd0; pc = 32'h88; req = 3'b010; sample(); adv();
        req = '0; sample();
        chk("single epc", epc[0], 32'h84); chk("single epc_we", 32'(epc_we[0]), 32'd1);
        chk("single vec", addr[0], 32'd254); chk("single busy", 32'(busy[0]), 32'd1); adv();
        sample(); chk("single hv", 32'(hv[0]), 32'd1); chk("single hpc", hpc[0], 32'h7C);
        chk("single busy2", 32'(busy[0]), 32'd1); adv();
        sample(); chk("single idle", 32'(busy[0]), 32'd0); adv();
        repeat (3) cyc();

        req = 3'b101; sample(); adv();
        req = '0; sample(); chk("simul vec0", addr[0], 32'd253); chk("simul c0", 32'(cause[0]), 32'd0); adv();
        sample(); chk("simul hv0", 32'(hv[0]), 32'd1); chk("simul hpc0", hpc[0], 32'h31); adv();
        sample(); chk("simul gap", 32'(busy[0]), 32'd0); adv();
        sample(); chk("simul vec2", addr[0], 32'd255); chk("simul c2", 32'(cause[0]), 32'd2); adv();
        sample(); chk("simul hv2", 32'(hv[0]), 32'd1); chk("simul hpc2", hpc[0], 32'hE6); adv();
        repeat (8) cyc();

        req = 3'b001; sample(); adv();
        req = 3'b010; sample(); chk("lat3 vec1", addr[1], 32'd253); adv();
        req = '0; sample(); chk("lat3 vec2", addr[1], 32'd253); adv();
        sample(); chk("lat3 vec3", addr[1], 32'd253); adv();
        sample(); chk("lat3 hv", 32'(hv[1]), 32'd1); chk("lat3 hpc", hpc[1], 32'h31); adv();
        sample(); chk("lat3 gap", 32'(busy[1]), 32'd0); adv();
        sample(); chk("lat3 next", addr[1], 32'd254); chk("lat3 c1", 32'(cause[1]), 32'd1); adv();
        repeat (6) cyc();

        req = 3'b001; sample(); adv();
        req = '0; rst_n = 1'b0; sample(); chk("abort vec", 32'(busy[1]), 32'd1); adv();
        rst_n = 1'b1; sample();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort d%0d busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("abort d%0d hv", d), 32'(hv[d]), 32'd0);
            chk($sformatf("abort d%0d hpc", d), hpc[d], 32'd0);
        end
        adv();
        repeat (4) begin
            sample(); chk("abort quiet", 32'(busy[0] | busy[1]), 32'd0); adv();
        end

        pc = 32'd0; req = 3'b001; sample(); adv();
        req = '0; sample(); chk("wrap epc u1", epc[0], 32'hFFFF_FFFC); chk("wrap epc u3", epc[1], 32'hFFFF_FFFC); adv();
        repeat (6) cyc();

        repeat (400) begin
            rst_n   = ($urandom_range(0, 79) != 0);
            src_sel = 2'($urandom_range(0, 3));
            pc      = $urandom;
            alu     = $urandom;
            res     = $urandom;
            req     = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            cyc();
        end
        rst_n = 1'b1; req = '0;
        repeat (8) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
